// File: rtl/serial_to_parallel_pkg.sv
// Shared definitions for the chunk-to-word reassembler.
package serial_to_parallel_pkg;

   // COLLECT: gathering chunks into the shift register.
   // FULL: a complete word is held on the output, waiting for handoff.
   typedef enum logic [0:0] {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } s2p_state_t;

endpackage

// File: rtl/serial_to_parallel.sv
// Reassembles S_WIDTH-bit chunks into P_WIDTH-bit words, first chunk in the MSBs.
// The output side uses valid/ready. The input side offers ready, but the source may
// ignore it; a refused chunk is reported with a one-cycle overrun pulse. An optional
// idle timeout discards a stalled partial word.
module serial_to_parallel
   import serial_to_parallel_pkg::*;
#(
   parameter int P_WIDTH        = 24,
   parameter int S_WIDTH        = 8,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               in_valid,
   input  logic [S_WIDTH-1:0] in_data,
   output logic               in_ready,
   output logic               out_valid,
   output logic [P_WIDTH-1:0] out_data,
   input  logic               out_ready,
   output logic               busy,
   output logic               overrun,
   output logic               timeout
);

   localparam int COUNT_MAX = P_WIDTH / S_WIDTH;
   localparam int CNT_W     = $clog2(COUNT_MAX);
   localparam int IDLE_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(COUNT_MAX - 1);
   localparam logic [IDLE_W-1:0] IDLE_LIM  = IDLE_W'(TIMEOUT_CYCLES);
   localparam bit                TO_ENABLE = (TIMEOUT_CYCLES > 0);

   s2p_state_t         state;
   logic [CNT_W-1:0]   count;
   logic [P_WIDTH-1:0] shift;
   logic [IDLE_W-1:0]  idle;

   logic               accept;
   logic [P_WIDTH-1:0] shift_next;
   logic [IDLE_W-1:0]  idle_inc;

   // Input handshake: always open while collecting; while full, a chunk may only
   // enter in the handoff cycle. flush closes the input for its duration.
   always_comb begin
      in_ready   = 1'b0;
      if (!flush) begin
         in_ready = (state == ST_COLLECT) ? 1'b1 : out_ready;
      end
      accept     = in_valid && in_ready;
      shift_next = {shift[P_WIDTH-S_WIDTH-1:0], in_data};
      idle_inc   = idle + IDLE_W'(1);
      busy       = (count != '0);
   end

   // Collect/hold FSM with shift register, held word, idle timer and status pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_COLLECT;
         count     <= '0;
         shift     <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         timeout   <= 1'b0;
         idle      <= '0;
      end else begin
         // A chunk dropped because of flush is intentional, not an overrun.
         overrun <= in_valid && !in_ready && !flush;
         timeout <= 1'b0;
         if (flush) begin
            state     <= ST_COLLECT;
            count     <= '0;
            shift     <= '0;
            out_valid <= 1'b0;
            idle      <= '0;
         end else begin
            case (state)
               ST_COLLECT: begin
                  if (accept) begin
                     shift <= shift_next;
                     idle  <= '0;
                     if (count == CNT_LAST) begin
                        out_data  <= shift_next;
                        out_valid <= 1'b1;
                        count     <= '0;
                        state     <= ST_FULL;
                     end else begin
                        count <= count + CNT_W'(1);
                     end
                  end else if (TO_ENABLE && (count != '0)) begin
                     // Stalled partial word: discard it once the idle limit is reached.
                     if (idle_inc == IDLE_LIM) begin
                        count   <= '0;
                        shift   <= '0;
                        idle    <= '0;
                        timeout <= 1'b1;
                     end else begin
                        idle <= idle_inc;
                     end
                  end
               end
               ST_FULL: begin
                  if (out_ready) begin
                     out_valid <= 1'b0;
                     state     <= ST_COLLECT;
                     // A chunk arriving in the handoff cycle starts the next word.
                     if (accept) begin
                        shift <= shift_next;
                        count <= CNT_W'(1);
                        idle  <= '0;
                     end
                  end
               end
               default: begin
                  state <= ST_COLLECT;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel (P=24, S=8, 16-cycle idle timeout).
module tb_serial_to_parallel;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        out_valid;
   logic [23:0] out_data;
   logic        out_ready;
   logic        busy;
   logic        overrun;
   logic        timeout;

   int n_cmp = 0;
   int n_err = 0;

   serial_to_parallel #(
      .P_WIDTH(24),
      .S_WIDTH(8),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_ready(out_ready),
      .busy(busy),
      .overrun(overrun),
      .timeout(timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen_to;
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      #12;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overrun", overrun, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_data", out_data, 0);
      @(negedge clk); rst = 1'b0;
      tick();

      // 1: back-to-back word, consumer ready
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'hAA; tick();
      chk("t1_busy_a", busy, 1);
      in_data = 8'hBB; tick();
      chk("t1_busy_b", busy, 1);
      chk("t1_novalid", out_valid, 0);
      in_data = 8'hCC; tick();
      in_valid = 1'b0;
      chk("t1_valid", out_valid, 1);
      chk("t1_data", out_data, 32'hAABBCC);
      chk("t1_busy_full", busy, 0);
      tick();
      chk("t1_handoff", out_valid, 0);
      chk("t1_data_kept", out_data, 32'hAABBCC);

      // 2: word held, extra chunk refused
      out_ready = 1'b0;
      send(8'hAA); send(8'hBB); send(8'hCC);
      chk("t2_valid", out_valid, 1);
      in_valid = 1'b1; in_data = 8'h11; #1;
      chk("t2_in_ready", in_ready, 0);
      tick();
      in_valid = 1'b0;
      chk("t2_overrun", overrun, 1);
      chk("t2_data_held", out_data, 32'hAABBCC);
      tick();
      chk("t2_overrun_end", overrun, 0);
      chk("t2_still_valid", out_valid, 1);

      // 3: handoff and new chunk in the same cycle
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 8'h01; #1;
      chk("t3_in_ready", in_ready, 1);
      tick();
      chk("t3_handoff", out_valid, 0);
      chk("t3_busy", busy, 1);
      chk("t3_no_overrun", overrun, 0);
      in_data = 8'h02; tick();
      in_data = 8'h03; tick();
      in_valid = 1'b0;
      chk("t3_valid", out_valid, 1);
      chk("t3_data", out_data, 32'h010203);
      tick();

      // 4: idle timeout discards partial word
      send(8'h12); send(8'h34);
      repeat (15) tick();
      chk("t4_no_timeout_yet", timeout, 0);
      chk("t4_busy_before", busy, 1);
      tick();
      chk("t4_timeout", timeout, 1);
      chk("t4_busy_after", busy, 0);
      tick();
      chk("t4_timeout_pulse", timeout, 0);
      send(8'h56); send(8'h78); send(8'h9A);
      chk("t4_valid", out_valid, 1);
      chk("t4_data", out_data, 32'h56789A);
      tick();

      // 5a: flush of a partial word, with a chunk offered during flush
      send(8'hDE); send(8'hAD);
      flush = 1'b1; in_valid = 1'b1; in_data = 8'hFF; #1;
      chk("t5_in_ready_flush", in_ready, 0);
      tick();
      flush = 1'b0; in_valid = 1'b0;
      chk("t5_busy", busy, 0);
      chk("t5_no_overrun", overrun, 0);
      seen_to = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         seen_to = seen_to | timeout;
      end
      chk("t5_no_timeout", seen_to, 0);
      // 5b: flush of a held word
      out_ready = 1'b0;
      send(8'hC1); send(8'hC2); send(8'hC3);
      chk("t5_full", out_valid, 1);
      flush = 1'b1; tick(); flush = 1'b0;
      chk("t5_flush_valid", out_valid, 0);
      chk("t5_flush_overrun", overrun, 0);
      out_ready = 1'b1;
      send(8'h12); send(8'h34); send(8'h56);
      chk("t5_clean_valid", out_valid, 1);
      chk("t5_clean_data", out_data, 32'h123456);
      tick();

      // 6: asynchronous reset between edges
      out_ready = 1'b0;
      send(8'h77); send(8'h88); send(8'h99);
      in_valid = 1'b1; in_data = 8'h55; tick(); in_valid = 1'b0;
      chk("t6_pre_overrun", overrun, 1);
      chk("t6_pre_valid", out_valid, 1);
      @(negedge clk); rst = 1'b1; #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_overrun", overrun, 0);
      @(negedge clk); rst = 1'b0;
      send(8'h42);
      chk("t6_mid_busy", busy, 1);
      @(negedge clk); rst = 1'b1; #1;
      chk("t6_rst_busy", busy, 0);
      @(negedge clk); rst = 1'b0;
      out_ready = 1'b1;
      send(8'hAB); send(8'hCD); send(8'hEF);
      chk("t6_valid", out_valid, 1);
      chk("t6_data", out_data, 32'hABCDEF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
